// File: rtl/keccak_pad_pkg.sv
// Shared definitions for the multi-rate Keccak/SHA-3 padder.
//   RATE_*       : block sizes in bits for each selectable rate
//   pad_mode_t   : 2-bit rate select (0..3 -> 1152/1088/832/576 bits)
//   pad_state_t  : padder FSM states
//   rate_bits()  : rate in bits for a given mode
package keccak_pad_pkg;

  localparam int RATE_224 = 1152;
  localparam int RATE_256 = 1088;
  localparam int RATE_384 = 832;
  localparam int RATE_512 = 576;

  typedef enum logic [1:0] {
    MODE_224 = 2'd0,
    MODE_256 = 2'd1,
    MODE_384 = 2'd2,
    MODE_512 = 2'd3
  } pad_mode_t;

  typedef enum logic [1:0] {
    ABSORB    = 2'd0,
    FILL      = 2'd1,
    LAST_FULL = 2'd2
  } pad_state_t;

  function automatic int rate_bits(input pad_mode_t m);
    case (m)
      MODE_224: return RATE_224;
      MODE_256: return RATE_256;
      MODE_384: return RATE_384;
      default:  return RATE_512;
    endcase
  endfunction

endpackage

// File: rtl/keccak_pad_word.sv
// Combinational final-word formatter.
//   in            : message word, valid bytes most-significant-first
//   byte_num      : number of valid bytes kept from the top of the word
//   ds            : domain-separation byte placed right after the valid bytes
//   last_in_block : word closes the block, so the trailing 0x80 lands in its lowest byte
//   out           : padded word
module keccak_pad_word
  #(parameter int W = 32)
  (
    input  logic [W-1:0]             in,
    input  logic [$clog2(W/8)-1:0]   byte_num,
    input  logic [7:0]               ds,
    input  logic                     last_in_block,
    output logic [W-1:0]             out
  );

  localparam int NB  = W / 8;
  localparam int BNW = $clog2(W / 8);

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_byte
      // Byte gi counts from the most significant end of the word.
      localparam int              SH  = W - 8 * (gi + 1);
      localparam logic [BNW-1:0]  IDX = BNW'(gi);
      logic [7:0] b;

      always_comb begin
        if (byte_num > IDX)
          b = in[SH +: 8];
        else if (byte_num == IDX)
          b = ds;
        else
          b = 8'h00;
      end

      // The lowest byte may carry both ds and the closing 0x80 (e.g. 0x86).
      if (gi == NB - 1) begin : g_low
        assign out[SH +: 8] = b | {last_in_block, 7'b0};
      end else begin : g_other
        assign out[SH +: 8] = b;
      end
    end
  endgenerate

endmodule

// File: rtl/keccak_padder_param.sv
// Multi-rate Keccak/SHA-3 padder: packs W-bit words into a rate-sized block,
// applies pad10*1 with a run-time domain byte and hands full blocks onward.
//   clk, reset  : clock, synchronous active-high reset
//   in          : message word (W bits), in_ready marks it valid
//   is_last     : final word of the message, byte_num = valid bytes in it
//   mode, ds    : rate select and domain byte, sampled on a message's first word
//   ack         : word accepted this cycle
//   buffer_full : block buffer holds R bits (out_ready mirrors it)
//   out         : block, first word at out[R-1 -: W], bits >= R are zero
//   f_ack       : consumer took the block (ignored unless full)
module keccak_padder_param
  import keccak_pad_pkg::*;
  #(
    parameter int W        = 32,
    parameter int MAX_RATE = 1152
  )
  (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [W-1:0]            in,
    input  logic                    in_ready,
    input  logic                    is_last,
    input  logic [$clog2(W/8)-1:0]  byte_num,
    input  logic [1:0]              mode,
    input  logic [7:0]              ds,
    output logic                    ack,
    output logic                    buffer_full,
    output logic [MAX_RATE-1:0]     out,
    output logic                    out_ready,
    input  logic                    f_ack
  );

  localparam int CW = $clog2(MAX_RATE / W + 1);

  pad_state_t          state_reg, state_next;
  logic [CW-1:0]       count_reg, count_next;
  logic [MAX_RATE-1:0] blk_reg, blk_next;
  logic                msg_active_reg, msg_active_next;
  pad_mode_t           mode_reg, mode_next;
  logic [7:0]          ds_reg, ds_next;

  pad_mode_t     mode_eff;
  logic [7:0]    ds_eff;
  logic [CW-1:0] n_words, n_eff;
  logic          full, last_in_block, accept;
  logic [W-1:0]  final_word, fill_word;

  // Before the first word of a message is taken, the live mode/ds apply;
  // afterwards the latched copies are used so mid-message changes are ignored.
  assign mode_eff = msg_active_reg ? mode_reg : pad_mode_t'(mode);
  assign ds_eff   = msg_active_reg ? ds_reg   : ds;

  assign n_words       = CW'(rate_bits(mode_reg) / W);
  assign n_eff         = CW'(rate_bits(mode_eff) / W);
  assign full          = (count_reg == n_words);
  assign last_in_block = ((count_reg + CW'(1)) == n_eff);
  assign accept        = (state_reg == ABSORB) && in_ready && !full && !reset;

  assign ack         = accept;
  assign buffer_full = full;
  assign out_ready   = full;
  // Words shift in from the bottom of a cleared buffer, so bits >= R stay zero.
  assign out         = blk_reg;

  keccak_pad_word #(.W(W)) u_pad_word (
    .in            (in),
    .byte_num      (byte_num),
    .ds            (ds_eff),
    .last_in_block (last_in_block),
    .out           (final_word)
  );

  always_comb begin
    fill_word      = '0;
    fill_word[7:0] = last_in_block ? 8'h80 : 8'h00;
  end

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    blk_next        = blk_reg;
    msg_active_next = msg_active_reg;
    mode_next       = mode_reg;
    ds_next         = ds_reg;

    case (state_reg)
      ABSORB: begin
        if (accept) begin
          count_next      = count_reg + CW'(1);
          msg_active_next = 1'b1;
          mode_next       = mode_eff;
          ds_next         = ds_eff;
          blk_next        = {blk_reg[MAX_RATE-W-1:0], is_last ? final_word : in};
          if (is_last)
            state_next = last_in_block ? LAST_FULL : FILL;
        end else if (full && f_ack) begin
          // Mid-message block handed off: keep absorbing into a fresh buffer.
          count_next = '0;
          blk_next   = '0;
        end
      end

      FILL: begin
        count_next = count_reg + CW'(1);
        blk_next   = {blk_reg[MAX_RATE-W-1:0], fill_word};
        if (last_in_block)
          state_next = LAST_FULL;
      end

      LAST_FULL: begin
        if (f_ack) begin
          count_next      = '0;
          blk_next        = '0;
          msg_active_next = 1'b0;
          state_next      = ABSORB;
        end
      end

      default: state_next = ABSORB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ABSORB;
      count_reg      <= '0;
      blk_reg        <= '0;
      msg_active_reg <= 1'b0;
      mode_reg       <= MODE_224;
      ds_reg         <= 8'h01;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      blk_reg        <= blk_next;
      msg_active_reg <= msg_active_next;
      mode_reg       <= mode_next;
      ds_reg         <= ds_next;
    end
  end

endmodule

// File: doc/keccak_padder_param.md
# keccak_padder_param

Parametrised multi-rate Keccak/SHA-3 padder. Sits between the UART byte-assembly front end and the Keccak-f permutation core: packs W-bit message words into a rate-sized block, applies pad10*1 with a run-time domain-separation byte, and hands full blocks to the core via `out_ready`/`f_ack`. Unlike the fixed 576-bit, 32-bit, Keccak-only padder, it selects the rate and suffix per message and returns to idle after the final block, so back-to-back messages need no reset.

## Interface
- `W`, 32: input word width in bits; multiple of 8, ≤64, divides every rate below.
- `MAX_RATE`, 1152: width of `out`; must be ≥ every selectable rate.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `in` in W: message word; valid bytes are most-significant-first.
- `in_ready` in 1: `in` valid this cycle.
- `is_last` in 1: final word of the message; only meaningful with `in_ready`.
- `byte_num` in $clog2(W/8): valid bytes in the final word, 0..W/8-1. A message ending on a word boundary sends an extra final word with `byte_num`=0.
- `mode` in 2: rate select, 0/1/2/3 → 1152/1088/832/576 bits. Sampled on the first accepted word of a message.
- `ds` in 8: domain byte: 0x01 Keccak, 0x06 SHA-3, 0x1F SHAKE. Sampled with `mode`.
- `ack` out 1: word accepted this cycle; user advances `in` only when `ack`=1.
- `buffer_full` out 1: block buffer holds R bits.
- `out` out MAX_RATE: block; first word at `out[R-1 -: W]`, last word at `out[W-1:0]`, bits ≥R forced to 0.
- `out_ready` out 1: equal to `buffer_full`.
- `f_ack` in 1: consumer took the block; honoured only while `out_ready`=1.

## Operation
- States: ABSORB, FILL, LAST_FULL.
- Reset: state ABSORB, word count 0, `out`=0, `ack`=0, `buffer_full`=`out_ready`=0, latched mode=0, ds=0x01.
- R = rate(latched mode); N = R/W words per block; word counter 0..N.
- `ack` = ABSORB & `in_ready` & !full. An accepted word shifts into the buffer, counter +1.
- Non-final word is written unchanged.
- Final word: keep top `byte_num` bytes; place `ds` in the next byte, zero the lower bytes; if the word is word N of the block, OR 0x80 into its lowest byte. If `ds` shares that byte, the byte is ds|0x80, e.g. 0x86. Then go to FILL, or to LAST_FULL if the block is now full.
- FILL: no `ack`; shift one zero word per cycle; word N gets 0x80 in its lowest byte; go to LAST_FULL when full.
- Full block in ABSORB, message not finished: `f_ack` clears the counter and absorbing resumes.
- LAST_FULL: hold `out` until `f_ack`, then ABSORB with counter 0, ready for a new message with freshly sampled `mode`/`ds`.
- If the final word arrives with `byte_num`=0 while the previous block is full, it waits; `ack` stays low until `f_ack`.
- `f_ack` while not full is ignored. `mode`/`ds` changes mid-message are ignored.

## Timing
- One word per cycle in ABSORB and FILL; no bubbles.
- `buffer_full` rises the cycle after the N-th word is written.
- The buffer is cleared by `f_ack` in the same edge; `ack` may assert the next cycle.
- Final word at index k (1-based) of the last block: `out_ready` rises N−k+1 cycles after its `ack`.
- `reset` wins over every other input in any state, including mid-FILL and while full.

## Structure
- Package `keccak_pad_pkg`:
  - Rate constants `RATE_224`/`256`/`384`/`512`.
  - `pad_mode_t` enum and `pad_state_t` enum.
  - `rate_bits(mode)` function.
- Sub-module `keccak_pad_word`: combinational final-word formatter, with inputs `in`, `byte_num`, `ds`, `last_in_block` producing the padded word. It generalises the 32-bit byte padder to W.

## Test plan
- Reset, then idle: `out`=0, `out_ready`=0, `ack`=0. `f_ack` pulses leave the state unchanged.
- Mode 1, ds 0x06, W=32, empty message (final word, `byte_num`=0): first word 0x06000000, then 33 fill cycles. `out_ready` rises 34 cycles after `ack`. `out[1087:1056]`=0x06000000, `out[7:0]`=0x80, `out[1151:1088]`=0.
- Mode 3, ds 0x06, 71 bytes (17 full words, then final 0xAABBCCxx with `byte_num`=3): word 18 = 0xAABBCC86. `out_ready` next cycle, no FILL.
- Mode 3, 72 bytes (18 full words): block full, `ack` low. After `f_ack`, the final word with `byte_num`=0 starts block 2: 0x06000000 … 0x00000080.
- Back-to-back: after the final `f_ack`, a new message in mode 0 with ds 0x1F is accepted without reset. Its block uses R=1152.
- Reset asserted mid-FILL and with a full buffer: next cycle all outputs are at reset values. A subsequent message pads correctly.
